// File: rtl/paillier_lite_cfg_master.sv
// paillier_lite_cfg_master: AXI-Lite master that programs the Paillier core
// (count low/high, control with start bit), then polls status until done,
// and reports done/error.
module paillier_lite_cfg_master #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter int          POLL_GAP                   = 16,
  parameter int          MAX_POLLS                  = 65535
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          INIT_AXI_TXN,
  input  logic [1:0]                    MODE,
  input  logic [63:0]                   TEST_TIMES,
  output logic                          BUSY,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, WR_CTRL, RD_STAT, GAP, FIN} state_t;

  localparam logic [31:0] BASE = C_M_TARGET_SLAVE_BASE_ADDR;

  state_t      state, state_nx;
  logic        init_q;
  logic        act;          // transaction of the current state has been issued
  logic        aw_done, w_done, b_done, resp_err;
  logic [1:0]  mode_q;
  logic [63:0] times_q;
  logic [15:0] polls;
  logic [31:0] gap_cnt;

  logic        rise, is_wr, aw_hs, w_hs, b_hs, r_hs;
  logic        wr_fin, wr_bad, rd_fin, rd_bad, poll_last, gap_end, rd_err;
  logic [16:0] polls_inc;
  logic [31:0] wr_off, wr_data;
  logic        unused_rdata;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

  assign rise      = INIT_AXI_TXN & ~init_q;
  assign is_wr     = (state == WR_LO) || (state == WR_HI) || (state == WR_CTRL);
  assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs      = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs      = M_AXI_BVALID  & M_AXI_BREADY;
  assign r_hs      = M_AXI_RVALID  & M_AXI_RREADY;
  // A write finishes once AW, W and B have all completed, counting this cycle's handshakes.
  assign wr_fin    = act & is_wr & (aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs);
  assign wr_bad    = resp_err | (b_hs & (M_AXI_BRESP != 2'b00));
  assign rd_fin    = act & (state == RD_STAT) & r_hs;
  assign rd_bad    = (M_AXI_RRESP != 2'b00);
  assign polls_inc = {1'b0, polls} + 17'd1;
  assign poll_last = (polls_inc >= 17'(MAX_POLLS));
  assign rd_err    = rd_bad | (~M_AXI_RDATA[0] & poll_last);
  assign gap_end   = (gap_cnt == 32'(POLL_GAP - 1));
  assign unused_rdata = ^M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:1];

  // Offset and payload of the write belonging to the current state.
  always_comb begin
    wr_off  = 32'h0;
    wr_data = {29'b0, mode_q, 1'b1};
    case (state)
      WR_LO:   begin wr_off = 32'h8; wr_data = times_q[31:0];  end
      WR_HI:   begin wr_off = 32'hC; wr_data = times_q[63:32]; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nx;
  end

  // Next-state: any bad response ends the sequence early.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise)    state_nx = WR_LO;
      WR_LO:   if (wr_fin)  state_nx = wr_bad ? FIN : WR_HI;
      WR_HI:   if (wr_fin)  state_nx = wr_bad ? FIN : WR_CTRL;
      WR_CTRL: if (wr_fin)  state_nx = wr_bad ? FIN : RD_STAT;
      RD_STAT: if (rd_fin)  state_nx = (rd_bad || M_AXI_RDATA[0] || poll_last) ? FIN : GAP;
      GAP:     if (gap_end) state_nx = RD_STAT;
      FIN:                  state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  // AXI channel drivers, sampled command, poll/gap counters and status flags.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      init_q        <= 1'b0;
      act           <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      b_done        <= 1'b0;
      resp_err      <= 1'b0;
      mode_q        <= 2'b0;
      times_q       <= 64'b0;
      polls         <= 16'b0;
      gap_cnt       <= 32'b0;
      BUSY          <= 1'b0;
      TXN_DONE      <= 1'b0;
      ERROR         <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      init_q   <= INIT_AXI_TXN;
      TXN_DONE <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          mode_q  <= MODE;
          times_q <= TEST_TIMES;
          BUSY    <= 1'b1;
          ERROR   <= 1'b0;
          polls   <= 16'b0;
          act     <= 1'b0;
        end
        WR_LO, WR_HI, WR_CTRL: begin
          if (!act) begin
            act           <= 1'b1;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_BREADY  <= 1'b1;
            M_AXI_AWADDR  <= C_M_AXI_ADDR_WIDTH'(BASE + wr_off);
            M_AXI_WDATA   <= C_M_AXI_DATA_WIDTH'(wr_data);
          end else begin
            if (aw_hs) begin M_AXI_AWVALID <= 1'b0; aw_done <= 1'b1; end
            if (w_hs)  begin M_AXI_WVALID  <= 1'b0; w_done  <= 1'b1; end
            if (b_hs) begin
              M_AXI_BREADY <= 1'b0;
              b_done       <= 1'b1;
              if (M_AXI_BRESP != 2'b00) resp_err <= 1'b1;
            end
            if (wr_fin) begin
              act      <= 1'b0;
              aw_done  <= 1'b0;
              w_done   <= 1'b0;
              b_done   <= 1'b0;
              resp_err <= 1'b0;
              if (wr_bad) ERROR <= 1'b1;
            end
          end
        end
        RD_STAT: begin
          if (!act) begin
            act           <= 1'b1;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_RREADY  <= 1'b1;
            M_AXI_ARADDR  <= C_M_AXI_ADDR_WIDTH'(BASE + 32'h4);
          end else begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
            if (rd_fin) begin
              M_AXI_RREADY <= 1'b0;
              act          <= 1'b0;
              polls        <= polls_inc[15:0];
              gap_cnt      <= 32'b0;
              if (rd_err) ERROR <= 1'b1;
            end
          end
        end
        GAP: gap_cnt <= gap_cnt + 32'd1;
        FIN: begin
          BUSY     <= 1'b0;
          TXN_DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
